// File: rtl/multireceive.sv
// Receive side of the keylock digit link: qualifies strobes, captures 3-bit digits MSB-first
// and rebuilds the decimal value. Optional idle timeout under MULTIRECEIVE_TIMEOUT_EN.
module multireceive #(
    parameter int unsigned DIGITS   = 6,
    parameter int unsigned HOLD_MIN = 1200,
    parameter int unsigned TIMEOUT  = 2400000
) (
    input  logic        hwclk,
    input  logic        rst,
    input  logic        in0,
    input  logic        in1,
    input  logic        in2,
    input  logic        controlIn,
    input  logic        enabled,
    output logic [31:0] num,
    output logic        valid,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, WAIT_HIGH, QUALIFY, WAIT_LOW, DONE} state_t;

    state_t      state, state_n;
    logic [1:0]  ctl_sync;
    logic [2:0]  dat_meta, dat_s;
    logic        ctl_s;
    logic        en_d;
    logic [31:0] acc, acc_n;
    logic [3:0]  count, count_n;
    logic [31:0] hold, hold_n;
    logic [31:0] num_n;
    logic        valid_n;
    logic        accept;

    assign ctl_s = ctl_sync[1];
    assign busy  = (state != IDLE);

`ifdef MULTIRECEIVE_TIMEOUT_EN
    logic [31:0] idle_cnt, idle_n;
    logic        error_n;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            ctl_sync <= '0;
            dat_meta <= '0;
            dat_s    <= '0;
            en_d     <= 1'b0;
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            hold     <= '0;
            num      <= '0;
            valid    <= 1'b0;
`ifdef MULTIRECEIVE_TIMEOUT_EN
            idle_cnt <= '0;
            error    <= 1'b0;
`endif
        end else begin
            ctl_sync <= {ctl_sync[0], controlIn};
            dat_meta <= {in2, in1, in0};
            dat_s    <= dat_meta;
            en_d     <= enabled;
            state    <= state_n;
            acc      <= acc_n;
            count    <= count_n;
            hold     <= hold_n;
            num      <= num_n;
            valid    <= valid_n;
`ifdef MULTIRECEIVE_TIMEOUT_EN
            idle_cnt <= idle_n;
            error    <= error_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        count_n = count;
        hold_n  = hold;
        num_n   = num;
        valid_n = 1'b0;
        accept  = 1'b0;
`ifdef MULTIRECEIVE_TIMEOUT_EN
        idle_n  = idle_cnt;
        error_n = error;
`endif
        case (state)
            IDLE: begin
                if (enabled && !en_d) begin
                    acc_n   = '0;
                    count_n = '0;
                    hold_n  = '0;
                    state_n = WAIT_HIGH;
`ifdef MULTIRECEIVE_TIMEOUT_EN
                    idle_n  = '0;
                    error_n = 1'b0;
`endif
                end
            end
            WAIT_HIGH: begin
                if (ctl_s) begin
                    hold_n  = 32'd1;
                    state_n = QUALIFY;
                end
            end
            QUALIFY: begin
                if (!ctl_s) begin
                    state_n = WAIT_HIGH;
                end else if (hold + 32'd1 >= HOLD_MIN) begin
                    accept  = 1'b1;
                    acc_n   = acc * 32'd10 + {29'd0, dat_s};
                    count_n = count + 4'd1;
                    state_n = WAIT_LOW;
                end else begin
                    hold_n = hold + 32'd1;
                end
            end
            WAIT_LOW: begin
                if (!ctl_s)
                    state_n = (count == 4'(DIGITS)) ? DONE : WAIT_HIGH;
            end
            DONE: begin
                num_n   = acc;
                valid_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Abort overrides everything, including a pending DONE publish.
        if (state != IDLE && !enabled) begin
            state_n = IDLE;
            num_n   = num;
            valid_n = 1'b0;
        end
`ifdef MULTIRECEIVE_TIMEOUT_EN
        else if (state == WAIT_HIGH || state == QUALIFY || state == WAIT_LOW) begin
            if (accept) begin
                idle_n = '0;
            end else if (idle_cnt + 32'd1 >= TIMEOUT) begin
                error_n = 1'b1;
                state_n = IDLE;
            end else begin
                idle_n = idle_cnt + 32'd1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_multireceive.sv
// Directed self-checking bench for multireceive with a shortened HOLD_MIN/TIMEOUT.
module tb_multireceive;

    localparam int unsigned HOLD = 8;
    localparam int unsigned TOUT = 200;
    localparam int unsigned HI   = 12;
    localparam int unsigned LO   = 12;

    logic        hwclk = 1'b0;
    logic        rst;
    logic        in0, in1, in2, controlIn, enabled;
    logic [31:0] num;
    logic        valid, busy, error;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned vcount = 0;
    int unsigned v0;
    logic        busy_at_valid = 1'b1;

    multireceive #(.DIGITS(6), .HOLD_MIN(HOLD), .TIMEOUT(TOUT)) dut (
        .hwclk(hwclk), .rst(rst), .in0(in0), .in1(in1), .in2(in2),
        .controlIn(controlIn), .enabled(enabled),
        .num(num), .valid(valid), .busy(busy), .error(error)
    );

    always #5 hwclk = ~hwclk;

    always @(negedge hwclk) begin
        if (valid) begin
            vcount        = vcount + 1;
            busy_at_valid = busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge hwclk);
    endtask

    task automatic send_digit(input logic [2:0] d, input int unsigned hi, input int unsigned lo);
        {in2, in1, in0} = d;
        tick(1);
        controlIn = 1'b1;
        tick(hi);
        controlIn = 1'b0;
        tick(lo);
    endtask

    task automatic start_frame();
        enabled = 1'b0;
        tick(2);
        enabled = 1'b1;
        tick(2);
    endtask

    task automatic send_digits(input logic [17:0] digs, input int unsigned n, input int unsigned hi);
        for (int unsigned i = 0; i < n; i++)
            send_digit(digs[17 - 3*i -: 3], hi, LO);
    endtask

    task automatic frame_check(input string tag, input logic [31:0] exp_num);
        tick(4);
        check({tag, "_num"}, num, exp_num);
        check({tag, "_valids"}, vcount - v0, 1);
        check({tag, "_busy_at_valid"}, {31'd0, busy_at_valid}, 0);
        check({tag, "_busy_after"}, {31'd0, busy}, 0);
    endtask

    initial begin
        rst = 1'b1; in0 = 0; in1 = 0; in2 = 0; controlIn = 0; enabled = 0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_num", num, 0);
        check("rst_valid", {31'd0, valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_error", {31'd0, error}, 0);

        // Basic frame 123456
        v0 = vcount;
        start_frame();
        check("t1_busy_mid", {31'd0, busy}, 1);
        send_digits({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, 6, HI);
        frame_check("t1", 32'd123456);

        // Glitch of HOLD_MIN-1 after first digit
        v0 = vcount;
        start_frame();
        send_digit(3'd7, HI, LO);
        send_digit(3'd5, HOLD - 1, LO);
        check("t2_no_early_valid", vcount - v0, 0);
        send_digits({3'd0, 3'd7, 3'd0, 3'd7, 3'd0, 3'd0}, 5, HI);
        frame_check("t2", 32'd707070);

        // Long strobes each yield exactly one digit
        v0 = vcount;
        start_frame();
        send_digits({3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3}, 6, 10 * HOLD);
        frame_check("t3", 32'd333333);

        // Abort after three digits keeps the previous value
        v0 = vcount;
        start_frame();
        send_digits({3'd1, 3'd2, 3'd3, 9'd0}, 3, HI);
        enabled = 1'b0;
        tick(3);
        check("t4_abort_busy", {31'd0, busy}, 0);
        check("t4_abort_num", num, 32'd333333);
        check("t4_abort_valids", vcount - v0, 0);
        v0 = vcount;
        start_frame();
        send_digits({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, 6, HI);
        frame_check("t4", 32'd1);

`ifdef MULTIRECEIVE_TIMEOUT_EN
        v0 = vcount;
        start_frame();
        send_digits({3'd4, 3'd4, 12'd0}, 2, HI);
        tick(TOUT / 2);
        check("t5_before_timeout_err", {31'd0, error}, 0);
        check("t5_before_timeout_busy", {31'd0, busy}, 1);
        tick(TOUT);
        check("t5_timeout_err", {31'd0, error}, 1);
        check("t5_timeout_busy", {31'd0, busy}, 0);
        check("t5_timeout_valids", vcount - v0, 0);
        start_frame();
        check("t5_err_cleared", {31'd0, error}, 0);
        enabled = 1'b0;
        tick(2);
`else
        check("no_timeout_error", {31'd0, error}, 0);
`endif

        // Asynchronous reset during QUALIFY of digit 4
        start_frame();
        send_digits({3'd1, 3'd2, 3'd3, 9'd0}, 3, HI);
        {in2, in1, in0} = 3'd4;
        tick(1);
        controlIn = 1'b1;
        tick(5);
        check("t6_busy_qualify", {31'd0, busy}, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_num", num, 0);
        check("t6_rst_busy", {31'd0, busy}, 0);
        check("t6_rst_valid", {31'd0, valid}, 0);
        check("t6_rst_error", {31'd0, error}, 0);
        tick(2);
        rst = 1'b0;
        controlIn = 1'b0;
        tick(2);
        v0 = vcount;
        start_frame();
        send_digits({3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, 6, HI);
        frame_check("t6", 32'd654321);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
